// File: rtl/instr_queue.sv
// Instruction queue between the aligner and the decoder.
// A circular buffer of DEPTH entries. Each entry holds the aligned instruction
// plus pre-decode computed at push time (RVC flag, branch/jump flag, prediction
// flag and misconduct code), so the decoder sees them with no extra logic.
// Optional feature: define INSTR_QUEUE_BYPASS_EN to let an instruction arriving
// at an empty queue drive the head outputs in the same cycle.
module instr_queue #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          s_clk_i,
  input  logic          s_resetn_i,
  input  logic          s_flush_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [31:0]   s_instr_i,
  input  logic [2:0]    s_fetch_error_i,
  input  logic          s_align_error_i,
  input  logic          s_prediction_i,
  output logic          s_valid_o,
  input  logic          s_ready_i,
  output logic [31:0]   s_instr_o,
  output logic [2:0]    s_imiscon_o,
  output logic          s_rvc_o,
  output logic          s_brj_o,
  output logic          s_pred_o,
  output logic [CW-1:0] s_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Fetch error codes; anything other than these two is a real fault that is
  // forwarded as the misconduct code.
  localparam logic [2:0] FETCH_VALID  = 3'd0;
  localparam logic [2:0] FETCH_INCER  = 3'd1;
  // Misconduct codes: FREE = clean, DSCR = discard (aligner error or bogus prediction).
  localparam logic [2:0] IMISCON_FREE = 3'd0;
  localparam logic [2:0] IMISCON_DSCR = 3'd1;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  function automatic logic f_is_rvc(input logic [31:0] ins);
    return ins[1:0] != 2'b11;
  endfunction

  function automatic logic f_is_brj(input logic [31:0] ins);
    logic r;
    r = 1'b0;
    if (ins[1:0] == 2'b11) begin
      r = (ins[6:0] == OPC_BRANCH) || (ins[6:0] == OPC_JAL) || (ins[6:0] == OPC_JALR);
    end else if (ins[1:0] == 2'b01) begin
      // c.jal, c.j, c.beqz, c.bnez
      r = (ins[15:13] == 3'b001) || (ins[15:13] == 3'b101) ||
          (ins[15:13] == 3'b110) || (ins[15:13] == 3'b111);
    end else if (ins[1:0] == 2'b10) begin
      // c.jr / c.jalr: rs2 == 0 and rs1 != 0
      r = (ins[15:13] == 3'b100) && (ins[6:2] == 5'd0) && (ins[11:7] != 5'd0);
    end
    return r;
  endfunction

  function automatic logic [2:0] f_imiscon(input logic [2:0] ferr, input logic aerr,
                                           input logic pred, input logic brj);
    logic [2:0] m;
    if (aerr)                                       m = IMISCON_DSCR;
    else if (ferr != FETCH_VALID && ferr != FETCH_INCER) m = ferr;
    else if (pred && !brj)                          m = IMISCON_DSCR;
    else                                            m = IMISCON_FREE;
    return m;
  endfunction

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_q   [DEPTH];
  logic [2:0]    imiscon_q [DEPTH];
  logic          rvc_q     [DEPTH];
  logic          brj_q     [DEPTH];
  logic          pred_q    [DEPTH];

  logic          in_rvc, in_brj;
  logic [2:0]    in_imiscon;
  logic          empty, bypass, push, pop;

  // Pre-decode of the incoming instruction
  always_comb begin
    in_rvc     = f_is_rvc(s_instr_i);
    in_brj     = f_is_brj(s_instr_i);
    in_imiscon = f_imiscon(s_fetch_error_i, s_align_error_i, s_prediction_i, in_brj);
  end

  assign empty     = (count_q == '0);
  // Ready depends on registered occupancy only, never on s_ready_i.
  assign s_ready_o = (count_q < CW'(DEPTH));
  assign s_count_o = count_q;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = empty & s_valid_i & ~s_flush_i;
`else
  assign bypass = 1'b0;
`endif

  // An instruction taken straight through the bypass is not stored.
  assign push = s_valid_i & s_ready_o & ~s_flush_i & ~(bypass & s_ready_i);
  assign pop  = ~empty & ~s_flush_i & s_ready_i;

  // Head output selection: bypassed input or the entry at the read pointer
  always_comb begin
    s_valid_o   = (~empty & ~s_flush_i) | bypass;
    s_instr_o   = instr_q[rptr_q];
    s_imiscon_o = imiscon_q[rptr_q];
    s_rvc_o     = rvc_q[rptr_q];
    s_brj_o     = brj_q[rptr_q];
    s_pred_o    = pred_q[rptr_q];
    if (bypass) begin
      s_instr_o   = s_instr_i;
      s_imiscon_o = in_imiscon;
      s_rvc_o     = in_rvc;
      s_brj_o     = in_brj;
      s_pred_o    = s_prediction_i;
    end
  end

  // Next-state for pointers and occupancy; flush restarts from zero
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (s_flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written with pre-decode at the write pointer on push
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= '0;
        imiscon_q[i] <= IMISCON_FREE;
        rvc_q[i]     <= 1'b0;
        brj_q[i]     <= 1'b0;
        pred_q[i]    <= 1'b0;
      end
    end else if (push) begin
      instr_q[wptr_q]   <= s_instr_i;
      imiscon_q[wptr_q] <= in_imiscon;
      rvc_q[wptr_q]     <= in_rvc;
      brj_q[wptr_q]     <= in_brj;
      pred_q[wptr_q]    <= s_prediction_i;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue (DEPTH = 4).
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush, vi, ae, pr, rdyi;
  logic [31:0] ins;
  logic [2:0]  fe;
  logic        rdyo, vo, rvc, brj, pred;
  logic [31:0] instro;
  logic [2:0]  imis;
  logic [2:0]  cnt;

  localparam logic [2:0] FREE = 3'd0;
  localparam logic [2:0] DSCR = 3'd1;

  int total = 0;
  int bad   = 0;

  logic [31:0] addi [0:4];
  int np, npop;

  instr_queue #(.DEPTH(4)) dut (
    .s_clk_i(clk), .s_resetn_i(rstn), .s_flush_i(flush),
    .s_valid_i(vi), .s_ready_o(rdyo), .s_instr_i(ins),
    .s_fetch_error_i(fe), .s_align_error_i(ae), .s_prediction_i(pr),
    .s_valid_o(vo), .s_ready_i(rdyi), .s_instr_o(instro),
    .s_imiscon_o(imis), .s_rvc_o(rvc), .s_brj_o(brj), .s_pred_o(pred),
    .s_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] i, input logic [2:0] f,
                     input logic a, input logic p, input logic r, input logic fl);
    vi = v; ins = i; fe = f; ae = a; pr = p; rdyi = r; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Push one instruction into an empty queue, check its pre-decode at the head, then pop it.
  task automatic pd(input string tag, input logic [31:0] i, input logic [2:0] f,
                    input logic a, input logic p,
                    input logic xrvc, input logic xbrj, input logic [2:0] xim);
    drv(1'b1, i, f, a, p, 1'b0, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk({tag, "_instr"}, instro, i);
    chk({tag, "_rvc"},   {31'd0, rvc}, {31'd0, xrvc});
    chk({tag, "_brj"},   {31'd0, brj}, {31'd0, xbrj});
    chk({tag, "_imis"},  {29'd0, imis}, {29'd0, xim});
    chk({tag, "_pred"},  {31'd0, pred}, {31'd0, p});
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    addi[0] = 32'h00100093; addi[1] = 32'h00200113; addi[2] = 32'h00300193;
    addi[3] = 32'h00400213; addi[4] = 32'h00500293;
    rstn = 1'b0;
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    // reset state
    chk("rst_valid", {31'd0, vo}, 32'd0);
    chk("rst_ready", {31'd0, rdyo}, 32'd1);
    chk("rst_count", {29'd0, cnt}, 32'd0);
    chk("rst_instr", instro, 32'd0);
    chk("rst_imis",  {29'd0, imis}, {29'd0, FREE});
    chk("rst_flags", {29'd0, rvc, brj, pred}, 32'd0);
    rstn = 1'b1;
    cyc();

    // fill with ADDIs while the decoder stalls
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, addi[k], 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("full_count", {29'd0, cnt}, 32'd4);
    chk("full_ready", {31'd0, rdyo}, 32'd0);
    chk("full_valid", {31'd0, vo}, 32'd1);
    chk("stall_head", instro, addi[0]);
    drv(1'b1, addi[4], 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fifth_ignored", {29'd0, cnt}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pop_order", instro, addi[k]);
      chk("pop_count", {29'd0, cnt}, 32'(4 - k));
      cyc();
    end
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("drained_count", {29'd0, cnt}, 32'd0);
    chk("drained_valid", {31'd0, vo}, 32'd0);

    // pre-decode and misconduct codes
    pd("cj_pred",     32'h0000A001, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, FREE);
    pd("addi_pred",   32'h00000013, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, DSCR);
    pd("addi_aerr",   32'h00000013, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, DSCR);
    pd("addi_ferr",   32'h00000013, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5);
    pd("addi_incer",  32'h00000013, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, FREE);
    pd("jal_pred",    32'h0000006F, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, FREE);
    pd("beq",         32'h00000063, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, FREE);
    pd("cjr_pred",    32'h00008082, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, FREE);
    pd("cjr_rs1zero", 32'h00008002, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, DSCR);

    // flush with a concurrent push at count 3
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, addi[k], 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    drv(1'b1, 32'h0000DEAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("flush_cnt_pre", {29'd0, cnt}, 32'd3);
    chk("flush_valid", {31'd0, vo}, 32'd0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_cnt_post", {29'd0, cnt}, 32'd0);
    chk("flush_vo_post", {31'd0, vo}, 32'd0);
    chk("flush_ready", {31'd0, rdyo}, 32'd1);

    // full queue, push held high while the decoder alternates pop/stall
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h1000 + k, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    np = 4;
    npop = 0;
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 32'h1000 + np, 3'd0, 1'b0, 1'b0, (i % 2 == 0), 1'b0);
      #1;
      chk("osc_count", {29'd0, cnt}, (i % 2 == 0) ? 32'd4 : 32'd3);
      chk("osc_ready", {31'd0, rdyo}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        chk("osc_head", instro, 32'h1000 + npop);
        npop++;
      end else begin
        np++;
      end
      cyc();
    end
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wrap_drain", instro, 32'h1000 + npop);
      npop++;
      cyc();
    end
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("wrap_empty", {29'd0, cnt}, 32'd0);

    // empty queue, push with decoder ready
    drv(1'b1, 32'h00A00513, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    chk("byp_valid", {31'd0, vo}, 32'd1);
    chk("byp_instr", instro, 32'h00A00513);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("byp_count", {29'd0, cnt}, 32'd0);
    chk("byp_vo_after", {31'd0, vo}, 32'd0);
`else
    chk("lat_valid0", {31'd0, vo}, 32'd0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("lat_valid1", {31'd0, vo}, 32'd1);
    chk("lat_instr", instro, 32'h00A00513);
    chk("lat_count", {29'd0, cnt}, 32'd1);
    cyc();
    #1;
    chk("lat_popped", {29'd0, cnt}, 32'd0);
`endif

    // asynchronous reset mid-cycle
    drv(1'b1, 32'h00000055, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drv(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("arst_pre", {29'd0, cnt}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_count", {29'd0, cnt}, 32'd0);
    chk("arst_valid", {31'd0, vo}, 32'd0);
    chk("arst_ready", {31'd0, rdyo}, 32'd1);
    chk("arst_instr", instro, 32'd0);
    #3;
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
